// File: rtl/avmm_scratch_slave_if.sv
// Avalon-MM bus bundle between the AFU master and the scratch slave.
// Command fields are driven by the master; stall and read return by the slave.
interface avmm_scratch_slave_if;
    logic [31:0] avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_write, avs_read, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_write, avs_read, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avmm_scratch_slave.sv
// Byte-enabled quadword scratch memory on Avalon-MM with fixed-latency pipelined reads.
// Optional random stall injection is enabled by defining AVMM_SCRATCH_SLAVE_RANDSTALL_EN.
module avmm_scratch_slave #(
    parameter int          DEPTH        = 64,
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                 Clk_400,
    input  logic                 SoftReset_n,
    avmm_scratch_slave_if.slave  avs,
    output logic [15:0]          err_count,
    output logic [3:0]           rd_inflight
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] BAD_DATA = 64'hBADD_BADD_BADD_BADD;
    localparam logic [3:0]  MAX_P    = 4'(MAX_PENDING);

    logic [63:0]             r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_vld_p;
    logic [63:0]             r_dat_p [READ_LATENCY];
    logic                    r_rel_p0;
    logic                    r_released;
    logic [15:0]             r_err;
    logic [3:0]              r_inflight;

    logic                    w_borrow;
    logic [31:0]             w_offset;
    logic                    w_in_range;
    logic [AW-1:0]           w_index;
    logic                    w_accept;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_bad;
    logic                    w_rd_done;
    logic                    w_stall_rand;

    // Borrow out of the subtraction flags addresses below BASE_ADDR.
    assign {w_borrow, w_offset} = {1'b0, avs.avs_address} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_borrow && (w_offset[2:0] == 3'd0) && (w_offset[31:AW+3] == '0);
    assign w_index    = w_offset[AW+2:3];

    assign w_accept  = (avs.avs_read | avs.avs_write) & !avs.avs_waitrequest;
    assign w_wr_acc  = w_accept & avs.avs_write & w_in_range;
    assign w_rd_acc  = w_accept & avs.avs_read & !avs.avs_write;
    assign w_bad     = w_accept & (!w_in_range | (avs.avs_read & avs.avs_write));
    assign w_rd_done = r_vld_p[READ_LATENCY-1];

`ifdef AVMM_SCRATCH_SLAVE_RANDSTALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall_rand = r_lfsr[0];
`else
    assign w_stall_rand = 1'b0;
`endif

    assign avs.avs_waitrequest   = !r_released | (r_inflight == MAX_P) | w_stall_rand;
    assign avs.avs_readdatavalid = r_vld_p[READ_LATENCY-1];
    assign avs.avs_readdata      = r_dat_p[READ_LATENCY-1];
    assign err_count             = r_err;
    assign rd_inflight           = r_inflight;

    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            for (int b = 0; b < 8; b++) begin
                if (avs.avs_byteenable[b]) begin
                    r_mem[w_index][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline stage 0 samples memory at the acceptance edge.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dat_p[i] <= '0;
            end
        end else begin
            r_vld_p[0] <= w_rd_acc;
            r_dat_p[0] <= w_in_range ? r_mem[w_index] : BAD_DATA;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
                r_dat_p[i] <= r_dat_p[i-1];
            end
        end
    end

    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_rel_p0   <= 1'b0;
            r_released <= 1'b0;
            r_err      <= '0;
            r_inflight <= '0;
        end else begin
            r_rel_p0   <= 1'b1;
            r_released <= r_rel_p0;
            if (w_bad && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
            case ({w_rd_acc, w_rd_done})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_scratch_slave.sv
// Scoreboard bench for avmm_scratch_slave: reference memory model predicts every
// read completion (data and cycle) and the error counter.
module tb_avmm_scratch_slave;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 4;
    localparam int          MAXP  = 2;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [63:0] BADD  = 64'hBADD_BADD_BADD_BADD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] err_count;
    logic [3:0]  rd_inflight;

    avmm_scratch_slave_if bus ();

    avmm_scratch_slave #(
        .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(MAXP), .BASE_ADDR(BASE)
    ) dut (
        .Clk_400(clk), .SoftReset_n(rst_n), .avs(bus.slave),
        .err_count(err_count), .rd_inflight(rd_inflight)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          mdl_err = 0;
    logic [63:0] mdl_mem [DEPTH];
    logic [63:0] exp_q [$];
    int          exp_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one accepted command at edge acc_cyc.
    task automatic model_accept(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [63:0] data, input logic [7:0] be, input int acc_cyc);
        logic [32:0] diff;
        logic        inr;
        int          idx;
        diff = {1'b0, addr} - {1'b0, BASE};
        inr  = !diff[32] && (diff[2:0] == 3'd0) && ((diff[31:0] >> 3) < DEPTH);
        idx  = int'(diff[31:0] >> 3);
        if (!inr || (rd && wr)) mdl_err++;
        if (rd && !wr) begin
            exp_q.push_back(inr ? mdl_mem[idx] : BADD);
            exp_cyc_q.push_back(acc_cyc + LAT - 1);
        end
        if (wr && inr) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic bus_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [63:0] data, input logic [7:0] be);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.avs_read       = rd;
        bus.avs_write      = wr;
        bus.avs_address    = addr;
        bus.avs_writedata  = data;
        bus.avs_byteenable = be;
        while (bus.avs_waitrequest && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.avs_waitrequest) begin
            check_eq("accept_timeout", 64'(bus.avs_waitrequest), 64'd0);
        end else begin
            model_accept(rd, wr, addr, data, be, cyc + 1);
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.avs_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_after_reset", 64'(bus.avs_waitrequest), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_waitreq"}, 64'(bus.avs_waitrequest), 64'd1);
        check_eq({tag, "_rdv"}, 64'(bus.avs_readdatavalid), 64'd0);
        check_eq({tag, "_rdata"}, bus.avs_readdata, 64'd0);
        check_eq({tag, "_err"}, 64'(err_count), 64'd0);
        check_eq({tag, "_inflight"}, 64'(rd_inflight), 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        exp_q.delete();
        exp_cyc_q.delete();
        mdl_err = 0;
    endtask

    // Completion monitor: compares each strobe against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.avs_readdatavalid) check_eq("rdv_in_reset", 64'(bus.avs_readdatavalid), 64'd0);
        end else begin
            if (bus.avs_readdatavalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_rdv", 64'(bus.avs_readdatavalid), 64'd0);
                end else begin
                    check_eq("rd_data", bus.avs_readdata, exp_q.pop_front());
                    check_eq("rd_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                end
            end
            if (rd_inflight > 4'(MAXP)) check_eq("inflight_cap", 64'(rd_inflight), 64'(MAXP));
            if (rd_inflight == 4'(MAXP)) check_eq("stall_at_cap", 64'(bus.avs_waitrequest), 64'd1);
        end
    end

    initial begin
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = '0;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_ready();

        // Basic write/readback, including the last word.
        bus_cmd(1'b0, 1'b1, BASE + 32'h18, 64'h0123_4567_89AB_CDEF, 8'hFF);
        bus_cmd(1'b1, 1'b0, BASE + 32'h18, 64'h0, 8'h00);
        bus_cmd(1'b0, 1'b1, BASE + 32'(8*(DEPTH-1)), 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        bus_cmd(1'b1, 1'b0, BASE + 32'(8*(DEPTH-1)), 64'h0, 8'h00);
        idle();
        drain("drain_basic");

        // Partial byteenable, then all-zero byteenable no-op.
        bus_cmd(1'b0, 1'b1, BASE + 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        bus_cmd(1'b1, 1'b0, BASE + 32'h20, 64'h0, 8'h00);
        bus_cmd(1'b0, 1'b1, BASE + 32'h20, 64'h1111_2222_3333_4444, 8'h00);
        bus_cmd(1'b1, 1'b0, BASE + 32'h20, 64'h0, 8'h00);
        bus_cmd(1'b0, 1'b1, BASE + 32'h20, 64'h1122_3344_5566_7788, 8'hA0);
        bus_cmd(1'b1, 1'b0, BASE + 32'h20, 64'h0, 8'h00);
        idle();
        drain("drain_partial");

        // Read-before-write ordering on word 0.
        bus_cmd(1'b1, 1'b0, BASE, 64'h0, 8'h00);
        bus_cmd(1'b0, 1'b1, BASE, 64'h55, 8'hFF);
        bus_cmd(1'b1, 1'b0, BASE, 64'h0, 8'h00);
        idle();
        drain("drain_order");

        // Continuous reads against the pending limit.
        for (int i = 0; i < 10; i++)
            bus_cmd(1'b1, 1'b0, BASE + 32'(8 * (i % 5)), 64'h0, 8'h00);
        idle();
        drain("drain_pending");
        check_eq("inflight_idle", 64'(rd_inflight), 64'd0);

        // Bad commands.
        bus_cmd(1'b1, 1'b0, BASE + 32'h4, 64'h0, 8'h00);
        idle();
        drain("drain_bad_rd");
        check_eq("err_misaligned_rd", 64'(err_count), 64'(mdl_err));
        bus_cmd(1'b0, 1'b1, BASE + 32'(8*DEPTH), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        idle();
        check_eq("err_oor_wr", 64'(err_count), 64'(mdl_err));
        bus_cmd(1'b1, 1'b0, BASE, 64'h0, 8'h00);
        bus_cmd(1'b1, 1'b1, BASE + 32'h28, 64'h0BAD_CAFE_0BAD_CAFE, 8'hFF);
        idle();
        check_eq("err_rd_wr", 64'(err_count), 64'(mdl_err));
        bus_cmd(1'b1, 1'b0, BASE + 32'h28, 64'h0, 8'h00);
        bus_cmd(1'b1, 1'b0, BASE - 32'h8, 64'h0, 8'h00);
        idle();
        drain("drain_bad");
        check_eq("err_below_base", 64'(err_count), 64'(mdl_err));

        // Reset one cycle after a read is accepted.
        bus_cmd(1'b1, 1'b0, BASE + 32'h18, 64'h0, 8'h00);
        @(negedge clk);
        bus.avs_read = 1'b0;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < LAT + 2; i++) @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        wait_ready();
        bus_cmd(1'b1, 1'b0, BASE + 32'h18, 64'h0, 8'h00);
        bus_cmd(1'b1, 1'b0, BASE, 64'h0, 8'h00);
        bus_cmd(1'b1, 1'b0, BASE + 32'h20, 64'h0, 8'h00);
        idle();
        drain("drain_after_reset");
        check_eq("err_after_reset", 64'(err_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_scratch_slave.md
# avmm_scratch_slave

Avalon-MM slave that terminates the AFU's 64-bit Avalon-MM master port (the `avs_*` bus at 400 MHz) with a byte-enabled quadword scratch memory. Reads are pipelined and return at a fixed, parameterised latency, with `avs_readdatavalid` as the completion strobe. Back-pressure on `avs_waitrequest` enforces a cap on in-flight reads. The block is the bus partner for AFU bring-up and for MMIO-to-AMM bridge verification, and it also serves as a stand-in for real AMM targets.

## Interface
- `DEPTH`, 64: number of 64-bit words; power of 2, 2..1024.
- `READ_LATENCY`, 2: cycles from read acceptance to `avs_readdatavalid`; 1..8.
- `MAX_PENDING`, 2: maximum in-flight reads; 1..`READ_LATENCY`.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 8-byte aligned.
- `Clk_400`  in  1  sole clock; all logic is rising-edge.
- `SoftReset_n`  in  1  asynchronous assert, active-low reset; deassertion is synchronised to `Clk_400` by the caller.
- `avs_address`  in  32  byte address of the command.
- `avs_write`  in  1  write command.
- `avs_read`  in  1  read command.
- `avs_writedata`  in  64  write data.
- `avs_byteenable`  in  8  per-byte write enable; bit i covers data[8i+7:8i].
- `avs_waitrequest`  out  1  stall; a command is accepted only in a cycle where this is low.
- `avs_readdata`  out  64  read data; valid only while `avs_readdatavalid` is high.
- `avs_readdatavalid`  out  1  single-cycle read completion strobe.
- `err_count`  out  16  saturating count of bad commands.
- `rd_inflight`  out  4  number of reads currently in flight.

## Operation
- **Accept:** a command is accepted at an edge where (`avs_read` | `avs_write`) & !`avs_waitrequest`. The master holds the command stable while stalled.
- **Decode:** offset = `avs_address` − `BASE_ADDR`. The command is in range if `avs_address` ≥ `BASE_ADDR`, offset[2:0] == 0, and offset>>3 < `DEPTH`. Word index = offset[log2(`DEPTH`)+2:3].
- **Write:** on acceptance, each enabled byte of mem[index] updates at that edge. Disabled bytes are unchanged. An all-zero byteenable is legal and is a no-op.
- **Read:** on acceptance, mem[index] is sampled at that edge (the pre-write value). Data travels a `READ_LATENCY`-stage valid/data shift pipeline. `byteenable` is ignored; all 64 bits are returned.
- **Bad commands:** each of the following increments `err_count` by 1, saturating at 16'hFFFF:
  - out-of-range or misaligned write: dropped;
  - out-of-range or misaligned read: still completes at normal latency, with data 64'hBADD_BADD_BADD_BADD;
  - `avs_read` & `avs_write` high together: executed as the write only; no read completion.
- **In-flight count:** `rd_inflight` increments on read acceptance and decrements when `avs_readdatavalid` is high. If both happen in the same cycle, it is unchanged.
- **Stall:** `avs_waitrequest` = !reset_released | (`rd_inflight` == `MAX_PENDING`) | stall_rand. It is a function of registers only, never of the `avs_*` inputs.
- Writes are never stalled by the pending-read limit alone? No: `avs_waitrequest` is one signal, so writes also stall while the read limit is reached.

## Timing
- **Read latency:** a read accepted at edge N drives `avs_readdatavalid` high for exactly one cycle, the cycle after edge N+`READ_LATENCY`−1. With latency 1, data is visible in the cycle following acceptance. Back-to-back reads complete back-to-back, in order.
- **Write visibility:** a write at edge N is visible to a read accepted at edge N+1 or later.
- **Reset values:** while `SoftReset_n` is low:
  - `avs_waitrequest` = 1;
  - `avs_readdatavalid` = 0;
  - `avs_readdata` = 0;
  - `err_count` = 0;
  - `rd_inflight` = 0;
  - memory = all zero;
  - pipeline flushed.
- **Reset release:** `avs_waitrequest` falls 1 cycle after the first edge with `SoftReset_n` high.
- **Reset mid-operation:** in-flight reads are discarded; no `avs_readdatavalid` occurs after reset assertion.

## Configuration
- **`AVMM_SCRATCH_SLAVE_RANDSTALL_EN` defined:**
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11) reset to 16'hACE1 advances every cycle;
  - stall_rand = lfsr[0];
  - stalls are injected on top of the pending limit to stress master back-pressure handling.
- **Not defined:** stall_rand = 0 and the LFSR is not built.

## Test plan
- **Basic write/readback:** after reset, write 64'h0123_4567_89AB_CDEF to BASE+0x18, then read it → `avs_readdatavalid` exactly `READ_LATENCY` cycles after acceptance, with data 64'h0123_4567_89AB_CDEF.
- **Partial byteenable:** write 64'hFFFF_FFFF_FFFF_FFFF with byteenable 8'h0F to a zeroed word, then read → 64'h0000_0000_FFFF_FFFF.
- **Read-before-write ordering:** read word 0 at edge N, write word 0 = 64'h55 at N+1, read word 0 at N+2 → returned data 0 then 64'h55, in order, on consecutive completion slots.
- **Pending limit:** `READ_LATENCY`=4, `MAX_PENDING`=2, `avs_read` held high continuously → `avs_waitrequest` high whenever 2 reads are in flight; `rd_inflight` never exceeds 2; every accepted read completes once.
- **Bad commands:**
  - address BASE+0x4 read → 64'hBADD_BADD_BADD_BADD, `err_count`=1;
  - address BASE+8·`DEPTH` write → memory unchanged, `err_count`=2;
  - read and write high together → write performed, no read completion, `err_count`=3.
- **Reset mid-read:** assert `SoftReset_n` low 1 cycle after a read is accepted → no `avs_readdatavalid`, all outputs at their reset values, memory reads back 0 after release.
